// File: rtl/issue_queue_pkg.sv
// Shared definitions for the issue queue and the reservation stations it feeds.
// Purpose : opcode constants, instruction field positions, the opcode class
//           type and small field-extraction helpers, so that every block
//           decodes instructions the same way.
// Ports   : none (package).
package issue_queue_pkg;

  // Default queue geometry
  localparam int IQ_DEPTH = 8;

  // Instruction word layout: [12:10] Rz, [9:7] Ry, [6:4] Rx, [3:0] opcode
  localparam int INST_W     = 16;
  localparam int OPCODE_W   = 4;
  localparam int OPCODE_LSB = 0;
  localparam int REG_W      = 3;
  localparam int RX_LSB     = 4;
  localparam int RY_LSB     = 7;
  localparam int RZ_LSB     = 10;

  // Opcodes understood by the reservation stations
  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_LD   = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_SD   = 4'b0011;

  // Which reservation station (if any) an opcode belongs to
  typedef enum logic [1:0] {
    CLASS_ADD     = 2'd0,
    CLASS_MEM     = 2'd1,
    CLASS_ILLEGAL = 2'd2
  } opclass_e;

  function automatic logic [OPCODE_W-1:0] getOpcode(input logic [INST_W-1:0] inst);
    return inst[OPCODE_LSB +: OPCODE_W];
  endfunction

  function automatic logic [REG_W-1:0] getRx(input logic [INST_W-1:0] inst);
    return inst[RX_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] getRy(input logic [INST_W-1:0] inst);
    return inst[RY_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] getRz(input logic [INST_W-1:0] inst);
    return inst[RZ_LSB +: REG_W];
  endfunction

  // Class lookup in one place so the decoder and any station agree
  function automatic opclass_e classifyOpcode(input logic [OPCODE_W-1:0] op);
    opclass_e cls;
    case (op)
      OP_ADD, OP_SUB, OP_ADDI: cls = CLASS_ADD;
      OP_LD, OP_SD:            cls = CLASS_MEM;
      default:                 cls = CLASS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/issue_queue_opclass_decode.sv
// Opcode class decoder for the issue queue head entry.
// Purpose : purely combinational; maps a 4-bit opcode onto exactly one of
//           the ADD, MEM or ILLEGAL classes.
// Ports   : i_opcode    - opcode field of the instruction
//           o_isAdd     - add/sub/addi, goes to the adder station
//           o_isMem     - ld/sd, goes to the load/store station
//           o_isIllegal - anything else, discarded by the queue
module opclass_decode
  import issue_queue_pkg::*;
(
  input  logic [OPCODE_W-1:0] i_opcode,
  output logic                o_isAdd,
  output logic                o_isMem,
  output logic                o_isIllegal
);

  opclass_e w_class;

  // Class selection is shared with the package so all users agree on it
  always_comb begin
    w_class     = classifyOpcode(i_opcode);
    o_isAdd     = 1'b0;
    o_isMem     = 1'b0;
    o_isIllegal = 1'b0;
    case (w_class)
      CLASS_ADD: o_isAdd     = 1'b1;
      CLASS_MEM: o_isMem     = 1'b1;
      default:   o_isIllegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/issue_queue.sv
// In-order instruction issue queue feeding an adder and a load/store
// reservation station.
// Purpose : circular FIFO of fetched instructions; each cycle the head entry
//           is either handed to its station (registered strobe), discarded
//           as illegal (registered pulse), or held until its station frees up.
// Ports   : i_clk, i_reset        - clock, synchronous active-high reset
//           i_instIn, i_instValid - enqueue request
//           o_instReady           - queue not full (registered count only)
//           i_disponivelAdd/Mem   - station has a free line
//           o_instruction         - last dispatched instruction
//           o_Adderin, o_LdSdin   - one-cycle capture strobes
//           o_illegalOp           - one-cycle pulse for a discarded head
//           o_count               - current occupancy
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [INST_W-1:0]        i_instIn,
  input  logic                     i_instValid,
  output logic                     o_instReady,
  input  logic                     i_disponivelAdd,
  input  logic                     i_disponivelMem,
  output logic [INST_W-1:0]        o_instruction,
  output logic                     o_Adderin,
  output logic                     o_LdSdin,
  output logic                     o_illegalOp,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // DEPTH is a power of two, so pointers wrap by plain overflow
  logic [INST_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [INST_W-1:0] r_instruction;
  logic              r_adderIn;
  logic              r_ldSdIn;
  logic              r_illegalOp;

  logic [INST_W-1:0] w_headInst;
  logic              w_isAdd;
  logic              w_isMem;
  logic              w_isIllegal;
  logic              w_notEmpty;
  logic              w_push;
  logic              w_dispAdd;
  logic              w_dispMem;
  logic              w_dropIllegal;
  logic              w_pop;

  assign w_headInst = r_mem[r_head];

  opclass_decode u_decode (
    .i_opcode    (getOpcode(w_headInst)),
    .o_isAdd     (w_isAdd),
    .o_isMem     (w_isMem),
    .o_isIllegal (w_isIllegal)
  );

  // Ready looks only at the registered count, so a pop in the same cycle
  // cannot make room for a push when the queue is full
  assign o_instReady = (r_count < CNT_W'(DEPTH));
  assign w_notEmpty  = (r_count != '0);
  assign w_push      = i_instValid & o_instReady;

  // Head decision: at most one outcome per cycle and only with a valid head.
  // A head whose station is busy blocks everything behind it.
  always_comb begin
    w_dispAdd     = 1'b0;
    w_dispMem     = 1'b0;
    w_dropIllegal = 1'b0;
    if (w_notEmpty) begin
      w_dispAdd     = w_isAdd & i_disponivelAdd;
      w_dispMem     = w_isMem & i_disponivelMem;
      w_dropIllegal = w_isIllegal;
    end
    w_pop = w_dispAdd | w_dispMem | w_dropIllegal;
  end

  // Storage is never cleared; entries outside head..tail are don't-care
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_tail] <= i_instIn;
    end
  end

  // Pointer and occupancy bookkeeping; reset wins over push and pop
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered dispatch outputs; strobes fall back to 0 every cycle and the
  // instruction bus keeps its value unless a station is being fed
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_instruction <= '0;
      r_adderIn     <= 1'b0;
      r_ldSdIn      <= 1'b0;
      r_illegalOp   <= 1'b0;
    end else begin
      r_adderIn   <= w_dispAdd;
      r_ldSdIn    <= w_dispMem;
      r_illegalOp <= w_dropIllegal;
      if (w_dispAdd || w_dispMem) begin
        r_instruction <= w_headInst;
      end
    end
  end

  assign o_instruction = r_instruction;
  assign o_Adderin     = r_adderIn;
  assign o_LdSdin      = r_ldSdIn;
  assign o_illegalOp   = r_illegalOp;
  assign o_count       = r_count;

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 DEPTH, 8, number of instruction entries; power of two, minimum 2.
REQ-002 Clock  input  1  single clock; all state updates on the rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 instIn  input  16  fetched instruction: [3:0] opcode, [12:10] Rz, [9:7] Ry, [6:4] Rx.
REQ-005 instValid  input  1  instIn is presented for enqueue this cycle.
REQ-006 instReady  output  1  queue accepts an instruction this cycle.
REQ-007 disponivelAdd  input  1  adder reservation station has a free line.
REQ-008 disponivelMem  input  1  load/store reservation station has a free line.
REQ-009 instruction  output  16  instruction driven to both reservation stations.
REQ-010 Adderin  output  1  one-cycle strobe; the adder station captures the instruction.
REQ-011 LdSdin  output  1  one-cycle strobe; the load/store station captures the instruction.
REQ-012 illegalOp  output  1  one-cycle pulse; the head entry was discarded as undecodable.
REQ-013 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-014 Circular FIFO with head and tail pointers of $clog2(DEPTH) bits each; pointers wrap from DEPTH-1 to 0.
REQ-015 instReady = (count < DEPTH), combinational from registered count only; dequeue in the same cycle does not raise it.
REQ-016 Enqueue when instValid && instReady at the edge; instIn is written at the tail and the tail advances; when instReady=0, instIn is ignored.
REQ-017 Opcode class: 0000, 0001, 0100 = ADD class; 0010, 0011 = MEM class (ld, sd); all others = ILLEGAL.
REQ-018 Dispatch is in order, at most one per edge, and only from the head while count > 0.
REQ-019 Head ADD and disponivelAdd=1 at the edge: register instruction <= head, Adderin <= 1, pop.
REQ-020 Head MEM and disponivelMem=1 at the edge: register instruction <= head, LdSdin <= 1, pop.
REQ-021 Head ILLEGAL: pop, illegalOp <= 1, instruction unchanged, no strobe.
REQ-022 Head class's station not disponivel: no pop, all strobes 0, head held (no bypass of younger entries).
REQ-023 Adderin, LdSdin and illegalOp are never high together; each is high for exactly one cycle per event.
REQ-024 The instruction output holds its last dispatched value between strobes.
REQ-025 Minimum latency: an instruction enqueued at edge N into an empty queue is strobed out in the cycle following edge N+1.
REQ-026 Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
REQ-027 Enqueue at count=DEPTH-1 with no dequeue: count=DEPTH, instReady falls next cycle.
REQ-028 Dequeue when count=0 never occurs; strobes stay 0 while empty.

Reset
REQ-029 Reset=1 at an edge: head=tail=0, count=0, instruction=16'h0000, Adderin=LdSdin=illegalOp=0; this takes priority over enqueue and dispatch.
REQ-030 Reset mid-operation discards all queued entries; no strobe is issued in the cycle after reset.
REQ-031 Storage array contents need not be cleared.

Structure
REQ-032 Opcode constants (OP_ADD=0000, OP_SUB=0001, OP_ADDI=0100, OP_LD=0010, OP_SD=0011) and field bit positions belong in a shared package with the reservation stations.
REQ-033 One sub-module, opclass_decode: combinational, 4-bit opcode -> {isAdd, isMem, isIllegal}.

Verification
REQ-034 After reset, push 16'h1C80 (add) with disponivelAdd=1 -> Adderin=1 and instruction=16'h1C80 two cycles after the push edge; count returns to 0.
REQ-035 Push 9 instructions back-to-back with both disponivel=0 -> instReady=0 after the 8th; the 9th is not stored; count=8.
REQ-036 Queue [add, ld 16'h0302]; disponivelAdd=0, disponivelMem=1 -> no strobe (in-order hold); raise disponivelAdd -> Adderin, then LdSdin on the next cycle.
REQ-037 Push opcode 1111 followed by a sub -> illegalOp pulses once, then Adderin carries the sub.
REQ-038 Continuous push and pop for 20 cycles across pointer wrap -> output order equals input order; count stays constant.
REQ-039 Assert Reset with 5 entries queued and dispatch pending -> all strobes 0 next cycle; count=0; instReady=1.
